// File: rtl/pulse_event_arbiter_pkg.sv
// Shared types for the pulse event arbiter: per-channel detect mode encoding.
package pulse_event_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF   = 2'd0,
        MODE_POS   = 2'd1,
        MODE_NEG   = 2'd2,
        MODE_PULSE = 2'd3
    } detect_mode_t;

endpackage

// File: rtl/pulse_event_arbiter_if.sv
// Bus between the event arbiter (master) and its driver/consumer (slave).
interface pulse_event_arbiter_if
    import pulse_event_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    parameter int unsigned CH_W = $clog2(N_CH)
);

    logic [N_CH-1:0]        a;
    logic [MODE_W*N_CH-1:0] mode;
    logic                   out_valid;
    logic [CH_W-1:0]        out_ch;
    logic                   out_ready;
    logic [N_CH-1:0]        ovf;
    logic [N_CH-1:0]        ovf_clr;

    modport master (
        input  a, mode, out_ready, ovf_clr,
        output out_valid, out_ch, ovf
    );

    modport slave (
        output a, mode, out_ready, ovf_clr,
        input  out_valid, out_ch, ovf
    );

endinterface

// File: rtl/pulse_event_arbiter_detector.sv
// Single-channel edge/pulse detector with a two-deep input history.
module edge_event_detector
    import pulse_event_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         a,
    input  detect_mode_t mode,
    output logic         ev
);

    logic r_h1;
    logic r_h2;

    // History runs every cycle regardless of mode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h1 <= 1'b0;
            r_h2 <= 1'b0;
        end else begin
            r_h1 <= a;
            r_h2 <= r_h1;
        end
    end

    always_comb begin
        ev = 1'b0;
        case (mode)
            MODE_POS:   ev = a & ~r_h1;
            MODE_NEG:   ev = ~a & r_h1;
            MODE_PULSE: ev = ~r_h2 & r_h1 & ~a;
            default:    ev = 1'b0;
        endcase
    end

endmodule

// File: rtl/pulse_event_arbiter.sv
// Latches per-channel detections as pending flags and serializes them
// round-robin onto a registered valid/ready channel-index stream.
module pulse_event_arbiter
    import pulse_event_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    parameter int unsigned CH_W = $clog2(N_CH)
)(
    input  logic                  clk,
    input  logic                  rst,
    pulse_event_arbiter_if.master bus
);

    logic [N_CH-1:0] w_ev;
    logic [N_CH-1:0] w_grant;
    logic [N_CH-1:0] w_ovf_set;
    logic [N_CH-1:0] r_pend;
    logic [N_CH-1:0] r_ovf;
    logic [CH_W-1:0] r_last;
    logic [CH_W-1:0] w_sel;
    logic            w_found;
    logic            w_load;
    logic            r_out_valid;
    logic [CH_W-1:0] r_out_ch;

    for (genvar c = 0; c < N_CH; c++) begin : g_det
        edge_event_detector u_det (
            .clk  (clk),
            .rst  (rst),
            .a    (bus.a[c]),
            .mode (detect_mode_t'(bus.mode[MODE_W*c +: MODE_W])),
            .ev   (w_ev[c])
        );
    end

    // First pending channel searching upward from last+1, wrapping at N_CH.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        w_found = 1'b0;
        w_sel   = r_last;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            idx = 32'(r_last) + i;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!w_found && r_pend[CH_W'(idx)]) begin
                w_found = 1'b1;
                w_sel   = CH_W'(idx);
            end
        end
    end

    assign w_load    = !r_out_valid || bus.out_ready;
    assign w_grant   = (w_load && w_found) ? (N_CH'(1) << w_sel) : '0;
    // A new event on a channel being loaded this cycle re-arms it, no overflow.
    assign w_ovf_set = w_ev & r_pend & ~w_grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend <= '0;
            r_ovf  <= '0;
        end else begin
            r_pend <= (r_pend & ~w_grant) | w_ev;
            r_ovf  <= (r_ovf & ~bus.ovf_clr) | w_ovf_set;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_last      <= CH_W'(N_CH - 1);
        end else if (w_load) begin
            r_out_valid <= w_found;
            if (w_found) begin
                r_out_ch <= w_sel;
                r_last   <= w_sel;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_ch    = r_out_ch;
    assign bus.ovf       = r_ovf;

endmodule
